regfile_arbiter: RTL and testbench

- Owns both ports of the card regfile (16 x 14-bit; bits [13:2] colour, [1:0] card state).
- Shares them between two write requesters:
  - A: compute_colors, full-word writes.
  - B: state_machine, state-field writes.
- Shares them between two read requesters:
  - Sweep: draw_cards refresh, all entries in order.
  - Single read: card_press_checker probe.
- Sits between those modules and regfile, replacing the current ad-hoc mux controller; all regfile-side outputs are registered.

---
 rtl/regfile_arbiter_if.sv | 45 ++++
 rtl/regfile_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if: requester-side and regfile-side signal bundle for
// regfile_arbiter. The arbiter connects through the slave modport; the
// requesters and the regfile see the master modport.
interface regfile_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 14
);
  logic              wa_req;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic              wa_gnt;
  logic              wb_req;
  logic [ADDR_W-1:0] wb_addr;
  logic [1:0]        wb_state;
  logic              wb_gnt;
  logic              sweep_start;
  logic              sweep_busy;
  logic              sweep_valid;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_done;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [1:0]        regfile_w_enable;
  logic [ADDR_W-1:0] regfile_w_address;
  logic [DATA_W-1:0] regfile_w_data;
  logic [ADDR_W-1:0] regfile_r_address;

  modport slave (
    input  wa_req, wa_addr, wa_data, wb_req, wb_addr, wb_state,
           sweep_start, rd_req, rd_addr,
    output wa_gnt, wb_gnt, sweep_busy, sweep_valid, sweep_addr, sweep_done,
           rd_gnt, rd_valid, regfile_w_enable, regfile_w_address,
           regfile_w_data, regfile_r_address
  );

  modport master (
    output wa_req, wa_addr, wa_data, wb_req, wb_addr, wb_state,
           sweep_start, rd_req, rd_addr,
    input  wa_gnt, wb_gnt, sweep_busy, sweep_valid, sweep_addr, sweep_done,
           rd_gnt, rd_valid, regfile_w_enable, regfile_w_address,
           regfile_w_data, regfile_r_address
  );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: owns both card regfile ports. The write port is shared by
// compute_colors (A, full word) and state_machine (B, state field only); the
// read port is shared by the draw_cards sweep and single card_press_checker
// probes. Every regfile-side output is a flop.
//
// Build option: define RR_WRITE_ARB_EN to arbitrate simultaneous A/B writes
// round-robin instead of fixed A-over-B priority.
//
// Read FSM states:
//   state  | meaning
//   IDLE   | no read in flight; accepts sweep_start (first) or rd_req
//   SWEEP  | stepping regfile_r_address 0..NUM_CARDS-1, one per cycle
//   DRAIN  | last address issued; waiting for its data and sweep_done
//   SINGLE | one probe address issued; counting down to rd_valid
module regfile_arbiter #(
  parameter int NUM_CARDS = 16,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 14,
  parameter int READ_LAT  = 1
) (
  input logic             clk,
  input logic             rst,
  regfile_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SWEEP, SINGLE, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CARDS - 1);
  localparam logic [1:0]        LAT_LOAD  = 2'(READ_LAT - 1);

  // write path
  logic              wa_gnt;
  logic              wb_gnt;
  logic [1:0]        w_enable;
  logic [ADDR_W-1:0] w_address;
  logic [DATA_W-1:0] w_data;
  logic              a_elig;
  logic              b_elig;
  logic              grant_a;
  logic              grant_b;

  // read path
  state_t            state;
  logic [ADDR_W-1:0] r_address;
  logic              sweep_busy;
  logic              s_issue;
  logic              s_last;
  logic              rd_gnt;
  logic              rd_valid;
  logic [1:0]        lat_cnt;
  logic              vpipe [READ_LAT];
  logic              lpipe [READ_LAT];
  logic [ADDR_W-1:0] apipe [READ_LAT];
  logic              sweep_done;

  // A requester granted this cycle sits out the next edge, so a level
  // request that is dropped one cycle late never produces a duplicate write.
  assign a_elig = bus.wa_req & ~wa_gnt;
  assign b_elig = bus.wb_req & ~wb_gnt;

`ifdef RR_WRITE_ARB_EN
  logic prio_b;

  // Pick the writer; on a tie the one not granted most recently wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_elig && b_elig) begin
      grant_a = ~prio_b;
      grant_b = prio_b;
    end else begin
      grant_a = a_elig;
      grant_b = b_elig;
    end
  end

  // Round-robin pointer: moves only when a write is actually issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_b <= 1'b0;
    end else if (grant_a) begin
      prio_b <= 1'b1;
    end else if (grant_b) begin
      prio_b <= 1'b0;
    end
  end
`else
  // Pick the writer; A always wins a tie.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    grant_a = a_elig;
    grant_b = b_elig & ~a_elig;
  end
`endif

  // Register the write strobe, address, data and the matching grant pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_enable  <= 2'b00;
      w_address <= '0;
      w_data    <= '0;
      wa_gnt    <= 1'b0;
      wb_gnt    <= 1'b0;
    end else begin
      w_enable <= 2'b00;
      wa_gnt   <= 1'b0;
      wb_gnt   <= 1'b0;
      if (grant_a) begin
        w_enable  <= 2'b01;
        w_address <= bus.wa_addr;
        w_data    <= bus.wa_data;
        wa_gnt    <= 1'b1;
      end else if (grant_b) begin
        w_enable  <= 2'b10;
        w_address <= bus.wb_addr;
        w_data    <= {{(DATA_W-2){1'b0}}, bus.wb_state};
        wb_gnt    <= 1'b1;
      end
    end
  end

  // Read FSM: drives the read address and the sweep/probe handshakes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      r_address  <= '0;
      sweep_busy <= 1'b0;
      s_issue    <= 1'b0;
      s_last     <= 1'b0;
      rd_gnt     <= 1'b0;
      rd_valid   <= 1'b0;
      lat_cnt    <= 2'd0;
    end else begin
      rd_gnt   <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          s_issue <= 1'b0;
          s_last  <= 1'b0;
          if (bus.sweep_start) begin
            r_address  <= '0;
            sweep_busy <= 1'b1;
            s_issue    <= 1'b1;
            if (LAST_ADDR == '0) begin
              s_last <= 1'b1;
              state  <= DRAIN;
            end else begin
              state <= SWEEP;
            end
          end else if (bus.rd_req) begin
            r_address <= bus.rd_addr;
            rd_gnt    <= 1'b1;
            lat_cnt   <= LAT_LOAD;
            state     <= SINGLE;
          end
        end
        SWEEP: begin
          s_issue <= 1'b1;
          if (r_address != LAST_ADDR) begin
            r_address <= r_address + 1'b1;
          end
          if (r_address >= LAST_ADDR - 1'b1) begin
            s_last <= 1'b1;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          s_issue <= 1'b0;
          s_last  <= 1'b0;
          if (sweep_done) begin
            sweep_busy <= 1'b0;
            state      <= IDLE;
          end
        end
        SINGLE: begin
          if (lat_cnt == 2'd0) begin
            rd_valid <= 1'b1;
            state    <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay the issued sweep address by the regfile read latency so the
  // valid/addr/done flags line up with regfile_r_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        vpipe[i] <= 1'b0;
        lpipe[i] <= 1'b0;
        apipe[i] <= '0;
      end
    end else begin
      vpipe[0] <= s_issue;
      lpipe[0] <= s_last;
      apipe[0] <= r_address;
      for (int i = 1; i < READ_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        lpipe[i] <= lpipe[i-1];
        apipe[i] <= apipe[i-1];
      end
    end
  end

  assign sweep_done = lpipe[READ_LAT-1];

  assign bus.wa_gnt            = wa_gnt;
  assign bus.wb_gnt            = wb_gnt;
  assign bus.regfile_w_enable  = w_enable;
  assign bus.regfile_w_address = w_address;
  assign bus.regfile_w_data    = w_data;
  assign bus.regfile_r_address = r_address;
  assign bus.sweep_busy        = sweep_busy;
  assign bus.sweep_valid       = vpipe[READ_LAT-1];
  assign bus.sweep_addr        = apipe[READ_LAT-1];
  assign bus.sweep_done        = sweep_done;
  assign bus.rd_gnt            = rd_gnt;
  assign bus.rd_valid          = rd_valid;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed bench for regfile_arbiter with a small regfile
// model behind it and queues of expected sweep, probe and write results.
module tb_regfile_arbiter;
  localparam int NUM_CARDS = 16;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 14;
  localparam int READ_LAT  = 1;

  typedef struct packed {
    logic              is_b;
    logic [1:0]        en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wexp_t;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   cyc;
  int   valid_cnt;
  int   done_cnt;
  int   done_cyc;

  logic [ADDR_W-1:0] sweep_q [$];
  logic [DATA_W-1:0] rd_q [$];
  wexp_t             w_q [$];

  logic [DATA_W-1:0] mem [NUM_CARDS];
  logic [DATA_W-1:0] r_data;

  regfile_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_arbiter #(
    .NUM_CARDS(NUM_CARDS),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pattern(input int a);
    return DATA_W'(a * 341 + 163);
  endfunction

  // Regfile model: one-cycle registered read, state-only write keeps colour.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CARDS; i++) mem[i] <= pattern(i);
    end else if (bus.regfile_w_enable == 2'b01) begin
      mem[bus.regfile_w_address] <= bus.regfile_w_data;
    end else if (bus.regfile_w_enable == 2'b10) begin
      mem[bus.regfile_w_address][1:0] <= bus.regfile_w_data[1:0];
    end
    r_data <= mem[bus.regfile_r_address];
  end

  function automatic logic [63:0] outs();
    return 64'({bus.wa_gnt, bus.wb_gnt, bus.sweep_busy, bus.sweep_valid,
                bus.sweep_addr, bus.sweep_done, bus.rd_gnt, bus.rd_valid,
                bus.regfile_w_enable, bus.regfile_w_address,
                bus.regfile_w_data, bus.regfile_r_address});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare whatever the DUT produced against the queues.
  task automatic tick();
    logic [ADDR_W-1:0] ea;
    wexp_t             ew;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.sweep_valid) begin
      valid_cnt++;
      check("sweep_pending", sweep_q.size() != 0, 1);
      if (sweep_q.size() != 0) begin
        ea = sweep_q.pop_front();
        check("sweep_addr", bus.sweep_addr, ea);
        check("sweep_data", r_data, pattern(int'(ea)));
      end
    end
    if (bus.sweep_done) begin
      check("done_with_valid", bus.sweep_valid, 1);
      check("done_addr", bus.sweep_addr, NUM_CARDS - 1);
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.rd_valid) begin
      check("rd_pending", rd_q.size() != 0, 1);
      if (rd_q.size() != 0) check("rd_data", r_data, rd_q.pop_front());
    end
    if (bus.wa_gnt || bus.wb_gnt || bus.regfile_w_enable != 2'b00) begin
      check("w_pending", w_q.size() != 0, 1);
      if (w_q.size() != 0) begin
        ew = w_q.pop_front();
        check("w_gnt", {bus.wb_gnt, bus.wa_gnt}, ew.is_b ? 2'b10 : 2'b01);
        check("w_enable", bus.regfile_w_enable, ew.en);
        check("w_address", bus.regfile_w_address, ew.addr);
        check("w_data", bus.regfile_w_data, ew.data);
      end
    end
  endtask

  task automatic full_sweep(input bit poke);
    int start_cyc;
    int v0;
    int d0;
    for (int a = 0; a < NUM_CARDS; a++) sweep_q.push_back(ADDR_W'(a));
    v0 = valid_cnt;
    d0 = done_cnt;
    start_cyc = cyc;
    bus.sweep_start = 1'b1;
    tick();
    bus.sweep_start = 1'b0;
    check("busy_start", bus.sweep_busy, 1);
    check("r_addr_0", bus.regfile_r_address, 0);
    for (int k = 1; k < NUM_CARDS; k++) begin
      bus.sweep_start = poke && (k == 8);
      tick();
      bus.sweep_start = 1'b0;
      check("r_addr_step", bus.regfile_r_address, k);
    end
    for (int i = 0; i < 10 && done_cnt == d0; i++) tick();
    check("done_seen", done_cnt, d0 + 1);
    check("done_cycle", done_cyc - start_cyc, NUM_CARDS + READ_LAT);
    check("busy_at_done", bus.sweep_busy, 1);
    tick();
    check("busy_clear", bus.sweep_busy, 0);
    check("valid_count", valid_cnt - v0, NUM_CARDS);
    check("sweep_q_empty", sweep_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] unused_mem0;
    bit found;
    int d0;
    int gnt_cyc;
    int fall_cyc;
    total = 0; passed = 0; cyc = 0; valid_cnt = 0; done_cnt = 0; done_cyc = 0;
    rst = 1'b0;
    bus.wa_req = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_req = 1'b0; bus.wb_addr = '0; bus.wb_state = 2'b00;
    bus.sweep_start = 1'b0; bus.rd_req = 1'b0; bus.rd_addr = '0;
    tick();
    tick();
    check("reset_outputs", outs(), 0);
    rst = 1'b1;
    tick();
    check("idle_outputs", outs(), 0);

    // full sweep from idle
    full_sweep(1'b0);

    // reset in the middle of a sweep
    for (int a = 0; a < NUM_CARDS; a++) sweep_q.push_back(ADDR_W'(a));
    bus.sweep_start = 1'b1;
    tick();
    bus.sweep_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (bus.sweep_valid && bus.sweep_addr == 4'd5) found = 1'b1;
    end
    check("reach_addr5", found, 1);
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1 check("mid_sweep_reset_outputs", outs(), 0);
    sweep_q.delete();
    tick();
    tick();
    check("no_done_after_abort", done_cnt, d0);
    rst = 1'b1;
    tick();

    // full sweep after reset; a second sweep_start mid-sweep must be ignored
    full_sweep(1'b1);

    // single probe read
    bus.rd_req = 1'b1;
    bus.rd_addr = 4'd6;
    tick();
    check("rd_gnt", bus.rd_gnt, 1);
    check("rd_r_address", bus.regfile_r_address, 6);
    rd_q.push_back(pattern(6));
    bus.rd_req = 1'b0;
    tick();
    check("rd_valid", bus.rd_valid, 1);
    tick();
    check("rd_valid_pulse", {bus.rd_valid, bus.rd_gnt}, 2'b00);
    check("rd_q_empty", rd_q.size(), 0);

    // sweep_start and rd_req together: sweep first, probe after busy falls
    for (int a = 0; a < NUM_CARDS; a++) sweep_q.push_back(ADDR_W'(a));
    bus.sweep_start = 1'b1;
    bus.rd_req = 1'b1;
    bus.rd_addr = 4'd1;
    gnt_cyc = -1;
    fall_cyc = -1;
    for (int i = 0; i < 40 && gnt_cyc < 0; i++) begin
      tick();
      bus.sweep_start = 1'b0;
      if (bus.rd_gnt) begin
        gnt_cyc = cyc;
        check("coll_gnt_not_busy", bus.sweep_busy, 0);
        check("coll_r_address", bus.regfile_r_address, 1);
        bus.rd_req = 1'b0;
        rd_q.push_back(pattern(1));
      end
      if (!bus.sweep_busy && fall_cyc < 0) fall_cyc = cyc;
    end
    check("coll_gnt_cycle", gnt_cyc, fall_cyc + 1);
    tick();
    check("coll_rd_q_empty", rd_q.size(), 0);
    check("coll_sweep_q_empty", sweep_q.size(), 0);

    // both writers held: strict alternation starting with A
    bus.wa_req = 1'b1; bus.wa_addr = 4'd2; bus.wa_data = 14'h1abc;
    bus.wb_req = 1'b1; bus.wb_addr = 4'd3; bus.wb_state = 2'b10;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) w_q.push_back('{is_b: 1'b0, en: 2'b01, addr: 4'd2, data: 14'h1abc});
      else            w_q.push_back('{is_b: 1'b1, en: 2'b10, addr: 4'd3, data: 14'h0002});
    end
    for (int i = 0; i < 6; i++) tick();
    bus.wa_req = 1'b0;
    bus.wb_req = 1'b0;
    tick();
    tick();
    check("contention_q_empty", w_q.size(), 0);
    check("w_idle_enable", bus.regfile_w_enable, 0);
    check("w_hold_address", bus.regfile_w_address, 3);
    check("w_hold_data", bus.regfile_w_data, 14'h0002);

    // A alone held: one write every other cycle
    bus.wa_req = 1'b1; bus.wa_addr = 4'd5; bus.wa_data = 14'h0123;
    w_q.push_back('{is_b: 1'b0, en: 2'b01, addr: 4'd5, data: 14'h0123});
    w_q.push_back('{is_b: 1'b0, en: 2'b01, addr: 4'd5, data: 14'h0123});
    for (int i = 0; i < 4; i++) tick();
    bus.wa_req = 1'b0;
    tick();
    check("a_alone_q_empty", w_q.size(), 0);

    // B alone: state-only write with zero colour bits
    bus.wb_req = 1'b1; bus.wb_addr = 4'd9; bus.wb_state = 2'b01;
    w_q.push_back('{is_b: 1'b1, en: 2'b10, addr: 4'd9, data: 14'h0001});
    tick();
    bus.wb_req = 1'b0;
    tick();
    check("b_alone_q_empty", w_q.size(), 0);

    // A wins once, then both eligible together after an idle cycle
    bus.wa_req = 1'b1; bus.wa_addr = 4'd4; bus.wa_data = 14'h2222;
    w_q.push_back('{is_b: 1'b0, en: 2'b01, addr: 4'd4, data: 14'h2222});
    tick();
    bus.wa_req = 1'b0;
    tick();
    bus.wa_req = 1'b1; bus.wa_data = 14'h3333;
    bus.wb_req = 1'b1; bus.wb_addr = 4'd3; bus.wb_state = 2'b10;
`ifdef RR_WRITE_ARB_EN
    w_q.push_back('{is_b: 1'b1, en: 2'b10, addr: 4'd3, data: 14'h0002});
    w_q.push_back('{is_b: 1'b0, en: 2'b01, addr: 4'd4, data: 14'h3333});
`else
    w_q.push_back('{is_b: 1'b0, en: 2'b01, addr: 4'd4, data: 14'h3333});
    w_q.push_back('{is_b: 1'b1, en: 2'b10, addr: 4'd3, data: 14'h0002});
`endif
    tick();
    tick();
    bus.wa_req = 1'b0;
    bus.wb_req = 1'b0;
    tick();
    check("tie_q_empty", w_q.size(), 0);

    unused_mem0 = mem[0];
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
